// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-port signals of mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        if_req_valid_i;
    logic        if_req_ready_o;
    logic [31:0] if_addr_i;
    logic        if_rsp_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_valid_i;
    logic        d_req_ready_o;
    logic [31:0] d_addr_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_wdata_i;
    logic        d_rsp_valid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  if_req_valid_i, if_addr_i, d_req_valid_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_req_ready_o, if_rsp_valid_o, if_rdata_o, d_req_ready_o, d_rsp_valid_o, d_rdata_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output if_req_valid_i, if_addr_i, d_req_valid_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rdata_o, d_req_ready_o, d_rsp_valid_o, d_rdata_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto one memory port, data first with a fetch starvation guard.
// Defining MEM_ARBITER_STATS_EN adds saturating grant counters stat_if_grants_o / stat_d_grants_o.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic          clock,
    input logic          reset_n,
    mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [15:0]  stat_if_grants_o,
    output logic [15:0]  stat_d_grants_o
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          if_win, d_win, if_acc, d_acc, ack;
    logic [31:0]   addr_q, wdata_q, if_rdata_q, d_rdata_q;
    logic [3:0]    be_q;
    logic          we_q, if_rsp_q, d_rsp_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Readys are gated by reset_n so they stay 0 while reset is held.
    always_comb begin
        if_win   = bus.if_req_valid_i && (!bus.d_req_valid_i || starve_q == SW'(STARVE_LIMIT));
        d_win    = bus.d_req_valid_i && !if_win;
        if_acc   = reset_n && state_q == IDLE && if_win;
        d_acc    = reset_n && state_q == IDLE && d_win;
        ack      = state_q != IDLE && bus.mem_ack_i;
        state_d  = state_q;
        starve_d = starve_q;
        if (if_acc) begin
            state_d  = BUSY_IF;
            starve_d = '0;
        end else if (d_acc) begin
            state_d  = BUSY_D;
            starve_d = (bus.if_req_valid_i && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
        end else if (ack) begin
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            if_rsp_q   <= 1'b0;
            d_rsp_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rsp_q <= ack && state_q == BUSY_IF;
            d_rsp_q  <= ack && state_q == BUSY_D;
            if (if_acc) begin
                addr_q  <= {bus.if_addr_i[31:2], 2'b00};
                we_q    <= 1'b0;
                be_q    <= 4'hF;
                wdata_q <= '0;
            end else if (d_acc) begin
                addr_q  <= {bus.d_addr_i[31:2], 2'b00};
                we_q    <= bus.d_we_i;
                be_q    <= bus.d_be_i;
                wdata_q <= bus.d_wdata_i;
            end
            if (ack && state_q == BUSY_IF) if_rdata_q <= bus.mem_rdata_i;
            if (ack && state_q == BUSY_D) d_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
        end
    end

    assign bus.if_req_ready_o = if_acc;
    assign bus.d_req_ready_o  = d_acc;
    assign bus.if_rsp_valid_o = if_rsp_q;
    assign bus.d_rsp_valid_o  = d_rsp_q;
    assign bus.if_rdata_o     = if_rdata_q;
    assign bus.d_rdata_o      = d_rdata_q;
    assign bus.mem_req_o      = state_q != IDLE;
    assign bus.mem_addr_o     = addr_q;
    assign bus.mem_we_o       = we_q;
    assign bus.mem_be_o       = be_q;
    assign bus.mem_wdata_o    = wdata_q;

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] stat_if_q, stat_d_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_if_q <= '0;
            stat_d_q  <= '0;
        end else begin
            if (if_acc && stat_if_q != 16'hFFFF) stat_if_q <= stat_if_q + 16'd1;
            if (d_acc && stat_d_q != 16'hFFFF) stat_d_q <= stat_d_q + 16'd1;
        end
    end
    assign stat_if_grants_o = stat_if_q;
    assign stat_d_grants_o  = stat_d_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a response scoreboard.
// Covers fetch, grant fairness, held-off store, spurious ack, mid-transaction reset and grant stats.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    typedef struct packed {logic d; logic [31:0] data;} exp_t;
    exp_t sb[$];
    mem_arbiter_if bus();
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] stat_if, stat_d;
`endif

    mem_arbiter dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_if_grants_o(stat_if),
        .stat_d_grants_o(stat_d)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Response monitor: every rsp pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (bus.if_rsp_valid_o || bus.d_rsp_valid_o) begin
            check("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_kind", {30'd0, bus.if_rsp_valid_o, bus.d_rsp_valid_o}, e.d ? 32'd1 : 32'd2);
                check("rsp_data", e.d ? bus.d_rdata_o : bus.if_rdata_o, e.data);
            end
        end
    end

    task automatic single(input logic is_d, input logic [31:0] addr, input logic we, input logic [31:0] rd);
        if (is_d) begin
            bus.d_req_valid_i = 1'b1;
            bus.d_addr_i      = addr;
            bus.d_we_i        = we;
            bus.d_be_i        = 4'hF;
            bus.d_wdata_i     = ~addr;
        end else begin
            bus.if_req_valid_i = 1'b1;
            bus.if_addr_i      = addr;
        end
        #1;
        check("acc_ready", is_d ? 32'(bus.d_req_ready_o) : 32'(bus.if_req_ready_o), 32'd1);
        tick();
        bus.if_req_valid_i = 1'b0;
        bus.d_req_valid_i  = 1'b0;
        check("acc_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
        check("acc_we", 32'(bus.mem_we_o), 32'(is_d && we));
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rd;
        sb.push_back('{is_d, (is_d && we) ? 32'd0 : rd});
        tick();
        bus.mem_ack_i = 1'b0;
    endtask

    initial begin
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = '0;
        bus.d_req_valid_i  = 1'b1;
        bus.d_addr_i       = '0;
        bus.d_we_i         = 1'b0;
        bus.d_be_i         = '0;
        bus.d_wdata_i      = '0;
        bus.mem_ack_i      = 1'b0;
        bus.mem_rdata_i    = '0;
        tick();
        tick();
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_if_ready", 32'(bus.if_req_ready_o), 32'd0);
        check("rst_d_ready", 32'(bus.d_req_ready_o), 32'd0);
        check("rst_if_rdata", bus.if_rdata_o, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        bus.if_req_valid_i = 1'b0;
        bus.d_req_valid_i  = 1'b0;
        reset_n = 1'b1;
        tick();
        // Fetch alone, ack two cycles after mem_req rises.
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'h0000_0013;
        #1;
        check("f_if_ready", 32'(bus.if_req_ready_o), 32'd1);
        check("f_d_ready", 32'(bus.d_req_ready_o), 32'd0);
        tick();
        bus.if_req_valid_i = 1'b0;
        check("f_mem_req", 32'(bus.mem_req_o), 32'd1);
        check("f_mem_addr", bus.mem_addr_o, 32'h10);
        check("f_mem_we", 32'(bus.mem_we_o), 32'd0);
        check("f_mem_be", 32'(bus.mem_be_o), 32'hF);
        check("f_mem_wdata", bus.mem_wdata_o, 32'd0);
        tick();
        check("f_mem_req2", 32'(bus.mem_req_o), 32'd1);
        tick();
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hCAFE_0001;
        sb.push_back('{1'b0, 32'hCAFE_0001});
        tick();
        bus.mem_ack_i = 1'b0;
        check("f_sb_drained", 32'(sb.size()), 32'd0);
        check("f_idle", 32'(bus.mem_req_o), 32'd0);
        tick();
        check("f_rdata_hold", bus.if_rdata_o, 32'hCAFE_0001);
        // Both requesters valid continuously: D,D,D,D,IF repeating.
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'h40;
        bus.d_req_valid_i  = 1'b1;
        bus.d_addr_i       = 32'h80;
        bus.d_we_i         = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            logic exp_if;
            exp_if = (i == 4 || i == 9);
            check($sformatf("grant%0d_if", i), 32'(bus.if_req_ready_o), 32'(exp_if));
            check($sformatf("grant%0d_d", i), 32'(bus.d_req_ready_o), 32'(!exp_if));
            sb.push_back('{!exp_if, 32'h100 + 32'(i)});
            tick();
            check($sformatf("grant%0d_addr", i), bus.mem_addr_o, exp_if ? 32'h40 : 32'h80);
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = 32'h100 + 32'(i);
            tick();
            bus.mem_ack_i = 1'b0;
        end
        bus.if_req_valid_i = 1'b0;
        bus.d_req_valid_i  = 1'b0;
        tick();
        // Store with ack held off five cycles.
        bus.d_req_valid_i = 1'b1;
        bus.d_addr_i      = 32'h24;
        bus.d_we_i        = 1'b1;
        bus.d_be_i        = 4'b0011;
        bus.d_wdata_i     = 32'hDEAD_BEEF;
        #1;
        check("st_d_ready", 32'(bus.d_req_ready_o), 32'd1);
        tick();
        bus.d_req_valid_i = 1'b0;
        bus.d_wdata_i     = 32'h0;
        bus.d_be_i        = 4'h0;
        for (int j = 0; j < 6; j++) begin
            if (j == 5) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = 32'h1234_5678;
                sb.push_back('{1'b1, 32'd0});
            end
            check($sformatf("st%0d_req", j), 32'(bus.mem_req_o), 32'd1);
            check($sformatf("st%0d_cmd", j), {bus.mem_addr_o[27:0], 3'd0, bus.mem_we_o},
                  {28'h24, 3'd0, 1'b1});
            check($sformatf("st%0d_be", j), 32'(bus.mem_be_o), 32'h3);
            check($sformatf("st%0d_wdata", j), bus.mem_wdata_o, 32'hDEAD_BEEF);
            tick();
        end
        bus.mem_ack_i = 1'b0;
        check("st_rdata_zero", bus.d_rdata_o, 32'd0);
        check("st_sb_drained", 32'(sb.size()), 32'd0);
        // Spurious ack in IDLE, then reset during BUSY_D.
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        tick();
        bus.mem_ack_i = 1'b0;
        check("sp_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("sp_if_rdata", bus.if_rdata_o, 32'h109);
        check("sp_d_rdata", bus.d_rdata_o, 32'd0);
        bus.d_req_valid_i = 1'b1;
        bus.d_addr_i      = 32'h50;
        bus.d_we_i        = 1'b0;
        #1;
        check("rb_d_ready", 32'(bus.d_req_ready_o), 32'd1);
        tick();
        bus.d_req_valid_i = 1'b0;
        check("rb_mem_req", 32'(bus.mem_req_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rb_async_drop", 32'(bus.mem_req_o), 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hAAAA_AAAA;
        tick();
        bus.mem_ack_i = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        check("rb_idle_req", 32'(bus.mem_req_o), 32'd0);
        check("rb_if_rdata", bus.if_rdata_o, 32'd0);
        check("rb_d_rdata", bus.d_rdata_o, 32'd0);
        // Three fetch and two data accepts after reset.
        single(1'b0, 32'h200, 1'b0, 32'h0000_0201);
        single(1'b1, 32'h304, 1'b0, 32'h0000_0305);
        single(1'b0, 32'h208, 1'b0, 32'h0000_0209);
        single(1'b1, 32'h30B, 1'b1, 32'h0000_030B);
        single(1'b0, 32'h20C, 1'b0, 32'h0000_020D);
        tick();
`ifdef MEM_ARBITER_STATS_EN
        check("stat_if", 32'(stat_if), 32'd3);
        check("stat_d", 32'(stat_d), 32'd2);
`endif
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive data grants while a fetch is pending.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req_valid_i  input  1  fetch request valid.
REQ-005 if_req_ready_o  output  1  fetch request accepted this cycle when also valid.
REQ-006 if_addr_i  input  32  fetch byte address.
REQ-007 if_rsp_valid_o  output  1  one-cycle pulse; if_rdata_o valid.
REQ-008 if_rdata_o  output  32  fetched instruction word.
REQ-009 d_req_valid_i, d_req_ready_o  input/output  1 each  data request handshake.
REQ-010 d_addr_i  input  32; d_we_i  input  1; d_be_i  input  4; d_wdata_i  input  32  data request fields.
REQ-011 d_rsp_valid_o  output  1  one-cycle completion pulse, loads and stores.
REQ-012 d_rdata_o  output  32  load data; 0 on store completion.
REQ-013 mem_req_o  output  1; mem_addr_o  output  32; mem_we_o  output  1; mem_be_o  output  4; mem_wdata_o  output  32  single memory port command.
REQ-014 mem_ack_i  input  1; mem_rdata_i  input  32  memory completion and read data, same cycle.

Function
REQ-015 FSM states IDLE, BUSY_IF, BUSY_D; at most one transaction outstanding.
REQ-016 In IDLE exactly one ready is asserted, combinationally, toward the winner among valid requesters; both readys 0 outside IDLE.
REQ-017 Priority: data wins over fetch, except fetch wins when starve counter equals STARVE_LIMIT.
REQ-018 Starve counter: +1 on each data grant while if_req_valid_i high, cleared on fetch grant, saturates at STARVE_LIMIT.
REQ-019 On accept (valid && ready) request fields are registered; state moves to BUSY_IF or BUSY_D next cycle.
REQ-020 In BUSY_*: mem_req_o = 1, command fields held stable from registered copy until and including ack cycle.
REQ-021 mem_addr_o = registered address with bits [1:0] forced 0; fetch drives mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
REQ-022 On mem_ack_i in BUSY_*: capture mem_rdata_i, pulse matching rsp_valid the following cycle, return to IDLE that same following cycle.
REQ-023 Latency: accept at cycle 0, mem_req_o from cycle 1; ack at cycle k gives rsp_valid at k+1; next accept possible at k+1.
REQ-024 mem_ack_i in IDLE is ignored; no rsp pulse, no state change.
REQ-025 rdata outputs hold last captured value between pulses; d_rdata_o = 0 for stores.
REQ-026 Requesters may drop valid before accept; no transaction results.

Reset
REQ-027 reset_n low immediately forces IDLE, starve counter 0, all outputs 0 (readys settle per REQ-016 after release).
REQ-028 Reset mid-transaction abandons it: mem_req_o drops asynchronously, no rsp pulse after release.

Configuration
REQ-029 Macro MEM_ARBITER_STATS_EN defined: ports stat_if_grants_o and stat_d_grants_o (16 bits each) count accepted requests, saturate at 16'hFFFF, reset to 0.
REQ-030 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-031 Fetch alone, addr 0x0000_0013, ack 2 cycles after mem_req -> mem_addr_o 0x10, if_rsp_valid_o pulse one cycle after ack with mem_rdata_i value.
REQ-032 Both valid in IDLE continuously, STARVE_LIMIT 4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-033 Store addr 0x24, be 4'b0011, wdata 0xDEAD_BEEF, ack held off 5 cycles -> command stable 5 cycles, d_rsp_valid_o pulse, d_rdata_o 0.
REQ-034 Spurious mem_ack_i in IDLE, then reset_n low during BUSY_D -> no rsp pulses, mem_req_o 0 at once, IDLE after release.
REQ-035 With MEM_ARBITER_STATS_EN, 3 fetch + 2 data accepts -> stat_if_grants_o 3, stat_d_grants_o 2; without it, ports absent and build clean.
